// File: rtl/rv_hazard_pkg.sv
// rv_hazard_pkg: shared types for the RV pipeline hazard controller.
package rv_hazard_pkg;
    typedef enum logic {HZ_RUN, HZ_MEM_WAIT} hz_state_e;
    localparam int REG_X0 = 0;
    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_bubble;
        logic pipe_freeze;
    } hz_ctrl_t;
endpackage

// File: rtl/rv_load_use_detect.sv
// rv_load_use_detect: flags an ID-stage read of a register still being loaded in EX.
module rv_load_use_detect
    import rv_hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic              idex_memread,
    input  logic [REG_AW-1:0] idex_rd,
    output logic              hazard
);
    assign hazard = idex_memread && idex_rd != REG_AW'(REG_X0) &&
                    ((id_uses_rs1 && id_rs1 == idex_rd) || (id_uses_rs2 && id_rs2 == idex_rd));
endmodule

// File: rtl/rv_hazard_ctrl.sv
// rv_hazard_ctrl: pipeline enables/bubbles/flushes for load-use, taken branch and
// multi-cycle dmem accesses with timeout, plus a saturating stall-cycle counter.
module rv_hazard_ctrl
    import rv_hazard_pkg::*;
#(
    parameter int REG_AW      = 5,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic              id_br_taken,
    input  logic              idex_memread,
    input  logic [REG_AW-1:0] idex_rd,
    input  logic              exmem_memread,
    input  logic              exmem_memwrite,
    input  logic              dmem_ready,
    output logic              dmem_req,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              pipe_freeze,
    output logic              mem_err,
    output logic [CNT_W-1:0]  stall_cycles
);
    localparam int TW = $clog2(MEM_TIMEOUT + 1);
    localparam hz_ctrl_t FREEZE = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                    idex_bubble: 1'b0, pipe_freeze: 1'b1};
    localparam hz_ctrl_t RESET  = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b1,
                                    idex_bubble: 1'b1, pipe_freeze: 1'b0};

    hz_state_e         state_q, state_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              err_q;
    logic [CNT_W-1:0]  stall_q;
    logic              load_use, memstall, released, timeout;
    hz_ctrl_t          run_ctrl, ctrl;

    rv_load_use_detect #(.REG_AW(REG_AW)) u_lud (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .idex_memread(idex_memread),
        .idex_rd     (idex_rd),
        .hazard      (load_use)
    );

    assign dmem_req = (exmem_memread | exmem_memwrite) & ~rst;
    assign memstall = dmem_req & ~dmem_ready;
    // Counter parked at MEM_TIMEOUT in RUN marks the one-cycle release after a timeout.
    assign released = state_q == HZ_RUN && tmo_q == TW'(MEM_TIMEOUT);
    assign timeout  = state_q == HZ_MEM_WAIT && !dmem_ready && tmo_q == TW'(MEM_TIMEOUT - 1);

    always_comb begin
        run_ctrl = load_use ? '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                idex_bubble: 1'b1, pipe_freeze: 1'b0}
                            : '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: id_br_taken,
                                idex_bubble: 1'b0, pipe_freeze: 1'b0};
        ctrl    = run_ctrl;
        state_d = state_q;
        tmo_d   = '0;
        if (state_q == HZ_RUN) begin
            if (memstall && !released) begin
                ctrl    = FREEZE;
                state_d = HZ_MEM_WAIT;
                tmo_d   = TW'(1);
            end
        end else if (dmem_ready) begin
            state_d = HZ_RUN;
        end else begin
            ctrl    = FREEZE;
            tmo_d   = tmo_q + TW'(1);
            state_d = timeout ? HZ_RUN : HZ_MEM_WAIT;
        end
        if (rst) ctrl = RESET;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HZ_RUN;
            tmo_q   <= '0;
            err_q   <= 1'b0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            err_q   <= err_q | timeout;
            if (!ctrl.pc_write && stall_q != '1) stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign pc_write     = ctrl.pc_write;
    assign ifid_write   = ctrl.ifid_write;
    assign ifid_flush   = ctrl.ifid_flush;
    assign idex_bubble  = ctrl.idex_bubble;
    assign pipe_freeze  = ctrl.pipe_freeze;
    assign mem_err      = err_q;
    assign stall_cycles = stall_q;
endmodule

// File: tb/tb_rv_hazard_ctrl.sv
// tb_rv_hazard_ctrl: vector table, corner sequences and random stimulus against a reference model.
module tb_rv_hazard_ctrl;
    localparam int AW = 5, MT = 16, CW = 6;
    localparam int SMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [AW-1:0] id_rs1 = '0, id_rs2 = '0, idex_rd = '0;
    logic id_uses_rs1 = 0, id_uses_rs2 = 0, id_br_taken = 0, idex_memread = 0;
    logic exmem_memread = 0, exmem_memwrite = 0, dmem_ready = 0;
    logic dmem_req, pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze, mem_err;
    logic [CW-1:0] stall_cycles;

    rv_hazard_ctrl #(.REG_AW(AW), .MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_br_taken(id_br_taken),
        .idex_memread(idex_memread), .idex_rd(idex_rd), .exmem_memread(exmem_memread),
        .exmem_memwrite(exmem_memwrite), .dmem_ready(dmem_ready), .dmem_req(dmem_req),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .pipe_freeze(pipe_freeze), .mem_err(mem_err),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic rst;
        logic [AW-1:0] rs1, rs2;
        logic u1, u2, br, imr;
        logic [AW-1:0] ird;
        logic emr, emw, rdy;
    } in_t;
    // expected bits: {dmem_req, pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze}
    typedef struct {
        in_t i;
        logic [5:0] e;
    } vec_t;

    int checks = 0, failures = 0;
    int m_frz = 0, m_stalls = 0;
    bit m_grace = 0, m_err = 0;
    logic [5:0] obs, exp_o;

    function automatic in_t mk(logic r, int rs1, int rs2, logic u1, logic u2, logic br,
                               logic imr, int ird, logic emr, logic emw, logic rdy);
        return '{rst: r, rs1: AW'(rs1), rs2: AW'(rs2), u1: u1, u2: u2, br: br, imr: imr,
                 ird: AW'(ird), emr: emr, emw: emw, rdy: rdy};
    endfunction

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    // Reference: an access freezes the pipe until ready or until MT freeze cycles
    // have elapsed; a timed-out access is then considered done for one cycle.
    function automatic logic [5:0] model_out(in_t v, output bit frozen);
        bit req, lu;
        req = (v.emr | v.emw) && !v.rst;
        lu = v.imr && v.ird != 0 && ((v.u1 && v.rs1 == v.ird) || (v.u2 && v.rs2 == v.ird));
        frozen = 0;
        if (v.rst) return 6'b000110;
        frozen = (m_frz > 0) ? !v.rdy : (req && !v.rdy && !m_grace);
        if (frozen) return {req, 5'b00001};
        if (lu) return {req, 5'b00010};
        return {req, 1'b1, 1'b1, v.br, 2'b00};
    endfunction

    task automatic tick(in_t v, string n);
        bit fr;
        @(negedge clk);
        rst = v.rst; id_rs1 = v.rs1; id_rs2 = v.rs2; id_uses_rs1 = v.u1; id_uses_rs2 = v.u2;
        id_br_taken = v.br; idex_memread = v.imr; idex_rd = v.ird;
        exmem_memread = v.emr; exmem_memwrite = v.emw; dmem_ready = v.rdy;
        #1;
        exp_o = model_out(v, fr);
        obs = {dmem_req, pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze};
        chk({n, " ctrl"}, 32'(obs), 32'(exp_o));
        chk({n, " stall_cycles"}, 32'(stall_cycles), 32'(m_stalls));
        chk({n, " mem_err"}, 32'(mem_err), 32'(m_err));
        @(posedge clk);
        if (v.rst) begin
            m_frz = 0; m_grace = 0; m_err = 0; m_stalls = 0;
        end else begin
            if (!exp_o[4]) m_stalls = (m_stalls < SMAX) ? m_stalls + 1 : SMAX;
            m_grace = 0;
            if (fr) begin
                m_frz++;
                if (m_frz == MT) begin m_err = 1; m_frz = 0; m_grace = 1; end
            end else m_frz = 0;
        end
    endtask

    in_t nop, lu5, rstv, mrd;
    vec_t tab[8];
    int fz;

    initial begin
        nop  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        lu5  = mk(0, 1, 5, 1, 1, 0, 1, 5, 0, 0, 1);
        rstv = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        mrd  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        tab[0] = '{mk(0, 1, 5, 1, 1, 0, 1, 5, 0, 0, 1), 6'b000010};
        tab[1] = '{mk(0, 0, 3, 1, 1, 0, 1, 0, 0, 0, 1), 6'b011000};
        tab[2] = '{mk(0, 2, 3, 1, 1, 1, 0, 2, 0, 0, 1), 6'b011100};
        tab[3] = '{mk(0, 7, 1, 1, 0, 1, 1, 7, 0, 0, 1), 6'b000010};
        tab[4] = '{mk(0, 1, 9, 1, 0, 0, 1, 9, 0, 0, 1), 6'b011000};
        tab[5] = '{mk(0, 4, 4, 1, 1, 0, 0, 4, 0, 0, 1), 6'b011000};
        tab[6] = '{mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1), 6'b111100};
        tab[7] = '{mk(1, 3, 3, 1, 1, 1, 1, 3, 1, 0, 0), 6'b000110};
        repeat (2) @(posedge clk);
        tick(rstv, "reset");
        chk("reset_lit", 32'(obs), 32'b000110);

        for (int k = 0; k < 8; k++) begin
            tick(tab[k].i, "table");
            chk($sformatf("table[%0d]_lit", k), 32'(obs), 32'(tab[k].e));
        end

        tick(rstv, "rst");
        tick(lu5, "lu");
        chk("lu_lit", 32'(obs), 32'b000010);
        tick(nop, "lu_next");
        chk("lu_release", 32'(pc_write), 1);
        chk("lu_stall_cnt", 32'(stall_cycles), 1);

        tick(rstv, "rst");
        fz = 0;
        repeat (3) begin tick(mrd, "mw3"); fz += obs[0]; end
        tick(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1), "mw3_ready");
        chk("mw3_release", 32'(obs), 32'b111000);
        chk("mw3_freeze_cnt", 32'(fz), 3);
        chk("mw3_stall_cnt", 32'(stall_cycles), 3);
        chk("mw3_err", 32'(mem_err), 0);

        tick(rstv, "rst");
        fz = 0;
        repeat (MT) begin tick(mrd, "tmo"); fz += obs[0]; end
        chk("tmo_freeze_cnt", 32'(fz), MT);
        tick(mrd, "tmo_grace");
        chk("tmo_grace_lit", 32'(obs), 32'b111000);
        chk("tmo_err", 32'(mem_err), 1);
        repeat (3) tick(nop, "tmo_after");
        chk("tmo_err_sticky", 32'(mem_err), 1);
        tick(rstv, "tmo_rst");
        tick(nop, "tmo_cleared");
        chk("tmo_err_cleared", 32'(mem_err), 0);

        tick(rstv, "rst");
        repeat (3) tick(mrd, "rmw");
        tick(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), "rmw_rst");
        chk("rmw_rst_lit", 32'(obs), 32'b000110);
        tick(nop, "rmw_after");
        chk("rmw_after_lit", 32'(obs), 32'b011000);
        chk("rmw_stall", 32'(stall_cycles), 0);
        chk("rmw_err", 32'(mem_err), 0);

        tick(rstv, "rst");
        repeat (SMAX + 8) tick(lu5, "sat");
        chk("sat_stall", 32'(stall_cycles), SMAX);

        for (int k = 0; k < 400; k++) begin
            in_t v;
            v.rst = $urandom_range(0, 39) == 0;
            v.rs1 = AW'($urandom_range(0, 3));
            v.rs2 = AW'($urandom_range(0, 3));
            v.u1  = 1'($urandom);
            v.u2  = 1'($urandom);
            v.br  = $urandom_range(0, 3) == 0;
            v.imr = 1'($urandom);
            v.ird = AW'($urandom_range(0, 3));
            v.emr = $urandom_range(0, 4) == 0;
            v.emw = $urandom_range(0, 5) == 0;
            v.rdy = $urandom_range(0, 3) != 0;
            tick(v, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
